// File: rtl/rs_entry_buffer.sv
// rtl/rs_entry_buffer.sv - reservation-station entry array with operand capture and registered issue slot
module rs_entry_buffer #(
  parameter int NENT    = 4,
  parameter int ENTLEN  = 2,
  parameter int VALLEN  = 8,
  parameter int TAGLEN  = 6,
  parameter int DATALEN = 32,
  parameter int OPLEN   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     alloc_valid_i,
  output logic                     alloc_ready_o,
  input  logic [OPLEN-1:0]         alloc_op_i,
  input  logic [VALLEN-1:0]        alloc_age_i,
  input  logic [TAGLEN-1:0]        alloc_src1_tag_i,
  input  logic [TAGLEN-1:0]        alloc_src2_tag_i,
  input  logic                     alloc_src1_rdy_i,
  input  logic                     alloc_src2_rdy_i,
  input  logic [DATALEN-1:0]       alloc_src1_data_i,
  input  logic [DATALEN-1:0]       alloc_src2_data_i,
  input  logic                     wakeup_valid_i,
  input  logic [TAGLEN-1:0]        wakeup_tag_i,
  input  logic [DATALEN-1:0]       wakeup_data_i,
  output logic [NENT*ENTLEN-1:0]   req_entry_vector_o,
  output logic [NENT*VALLEN-1:0]   req_value_vector_o,
  output logic                     any_ready_o,
  input  logic [ENTLEN-1:0]        oldest_entry_i,
  input  logic                     issue_stall_i,
  output logic                     issue_valid_o,
  output logic [OPLEN-1:0]         issue_op_o,
  output logic [VALLEN-1:0]        issue_age_o,
  output logic [DATALEN-1:0]       issue_src1_o,
  output logic [DATALEN-1:0]       issue_src2_o
);

  logic [NENT-1:0]    valid_q, valid_d;
  logic [NENT-1:0]    s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
  logic [OPLEN-1:0]   op_q [NENT], op_d [NENT];
  logic [VALLEN-1:0]  age_q [NENT], age_d [NENT];
  logic [TAGLEN-1:0]  s1_tag_q [NENT], s1_tag_d [NENT];
  logic [TAGLEN-1:0]  s2_tag_q [NENT], s2_tag_d [NENT];
  logic [DATALEN-1:0] s1_data_q [NENT], s1_data_d [NENT];
  logic [DATALEN-1:0] s2_data_q [NENT], s2_data_d [NENT];

  logic               issue_valid_q, issue_valid_d;
  logic [OPLEN-1:0]   issue_op_q, issue_op_d;
  logic [VALLEN-1:0]  issue_age_q, issue_age_d;
  logic [DATALEN-1:0] issue_src1_q, issue_src1_d;
  logic [DATALEN-1:0] issue_src2_q, issue_src2_d;

  logic [NENT-1:0]    ready;
  logic [ENTLEN-1:0]  alloc_idx;
  logic               alloc_fire;
  logic               issue_fire;
  logic               s1_bypass;
  logic               s2_bypass;

  assign ready         = valid_q & s1_rdy_q & s2_rdy_q;
  assign any_ready_o   = |ready;
  assign alloc_ready_o = ~&valid_q;
  assign alloc_fire    = alloc_valid_i & alloc_ready_o;
  // a bad index from the tree (non-ready entry) simply suppresses the issue
  assign issue_fire    = any_ready_o & ~issue_stall_i & ready[oldest_entry_i];
  assign s1_bypass     = wakeup_valid_i & ~alloc_src1_rdy_i & (alloc_src1_tag_i == wakeup_tag_i);
  assign s2_bypass     = wakeup_valid_i & ~alloc_src2_rdy_i & (alloc_src2_tag_i == wakeup_tag_i);

  assign issue_valid_o = issue_valid_q;
  assign issue_op_o    = issue_op_q;
  assign issue_age_o   = issue_age_q;
  assign issue_src1_o  = issue_src1_q;
  assign issue_src2_o  = issue_src2_q;

  // per-entry index and age requests; non-ready entries present the all-ones age
  for (genvar k = 0; k < NENT; k++) begin : g_req
    assign req_entry_vector_o[k*ENTLEN +: ENTLEN] = ENTLEN'(k);
    assign req_value_vector_o[k*VALLEN +: VALLEN] = ready[k] ? age_q[k] : {VALLEN{1'b1}};
  end

  // lowest-index free entry receives the next allocation
  always_comb begin
    alloc_idx = '0;
    for (int k = NENT - 1; k >= 0; k--) begin
      if (!valid_q[k]) alloc_idx = ENTLEN'(k);
    end
  end

  // next-state: wakeup capture, issue into the slot, then allocation into a free entry
  always_comb begin
    valid_d      = valid_q;
    s1_rdy_d     = s1_rdy_q;
    s2_rdy_d     = s2_rdy_q;
    op_d         = op_q;
    age_d        = age_q;
    s1_tag_d     = s1_tag_q;
    s2_tag_d     = s2_tag_q;
    s1_data_d    = s1_data_q;
    s2_data_d    = s2_data_q;
    issue_valid_d = issue_valid_q;
    issue_op_d    = issue_op_q;
    issue_age_d   = issue_age_q;
    issue_src1_d  = issue_src1_q;
    issue_src2_d  = issue_src2_q;

    for (int k = 0; k < NENT; k++) begin
      if (wakeup_valid_i && valid_q[k]) begin
        if (!s1_rdy_q[k] && s1_tag_q[k] == wakeup_tag_i) begin
          s1_rdy_d[k]  = 1'b1;
          s1_data_d[k] = wakeup_data_i;
        end
        if (!s2_rdy_q[k] && s2_tag_q[k] == wakeup_tag_i) begin
          s2_rdy_d[k]  = 1'b1;
          s2_data_d[k] = wakeup_data_i;
        end
      end
    end

    if (!issue_stall_i) begin
      issue_valid_d = issue_fire;
      if (issue_fire) begin
        issue_op_d              = op_q[oldest_entry_i];
        issue_age_d             = age_q[oldest_entry_i];
        issue_src1_d            = s1_data_q[oldest_entry_i];
        issue_src2_d            = s2_data_q[oldest_entry_i];
        valid_d[oldest_entry_i] = 1'b0;
      end
    end

    // alloc_idx is free in registered state, so it never collides with the issued entry
    if (alloc_fire) begin
      valid_d[alloc_idx]   = 1'b1;
      op_d[alloc_idx]      = alloc_op_i;
      age_d[alloc_idx]     = alloc_age_i;
      s1_tag_d[alloc_idx]  = alloc_src1_tag_i;
      s2_tag_d[alloc_idx]  = alloc_src2_tag_i;
      s1_rdy_d[alloc_idx]  = alloc_src1_rdy_i | s1_bypass;
      s2_rdy_d[alloc_idx]  = alloc_src2_rdy_i | s2_bypass;
      s1_data_d[alloc_idx] = s1_bypass ? wakeup_data_i : alloc_src1_data_i;
      s2_data_d[alloc_idx] = s2_bypass ? wakeup_data_i : alloc_src2_data_i;
    end
  end

  // state registers; reset drops every entry and the issue slot at once
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q       <= '0;
      s1_rdy_q      <= '0;
      s2_rdy_q      <= '0;
      for (int k = 0; k < NENT; k++) begin
        op_q[k]      <= '0;
        age_q[k]     <= '0;
        s1_tag_q[k]  <= '0;
        s2_tag_q[k]  <= '0;
        s1_data_q[k] <= '0;
        s2_data_q[k] <= '0;
      end
      issue_valid_q <= 1'b0;
      issue_op_q    <= '0;
      issue_age_q   <= '0;
      issue_src1_q  <= '0;
      issue_src2_q  <= '0;
    end else begin
      valid_q       <= valid_d;
      s1_rdy_q      <= s1_rdy_d;
      s2_rdy_q      <= s2_rdy_d;
      op_q          <= op_d;
      age_q         <= age_d;
      s1_tag_q      <= s1_tag_d;
      s2_tag_q      <= s2_tag_d;
      s1_data_q     <= s1_data_d;
      s2_data_q     <= s2_data_d;
      issue_valid_q <= issue_valid_d;
      issue_op_q    <= issue_op_d;
      issue_age_q   <= issue_age_d;
      issue_src1_q  <= issue_src1_d;
      issue_src2_q  <= issue_src2_d;
    end
  end

  // the all-ones age is reserved as "not ready" and must never be allocated
  always_ff @(posedge clk_i) begin
    if (rst_n_i && alloc_fire) assert (alloc_age_i != {VALLEN{1'b1}});
  end

endmodule

// File: tb/tb_rs_entry_buffer.sv
// tb/tb_rs_entry_buffer.sv - directed scoreboard bench for rs_entry_buffer
module tb_rs_entry_buffer;
  localparam int NENT = 4, ENTLEN = 2, VALLEN = 8, TAGLEN = 6, DATALEN = 32, OPLEN = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic alloc_valid, alloc_ready;
  logic [OPLEN-1:0] alloc_op;
  logic [VALLEN-1:0] alloc_age;
  logic [TAGLEN-1:0] alloc_t1, alloc_t2;
  logic alloc_r1, alloc_r2;
  logic [DATALEN-1:0] alloc_d1, alloc_d2;
  logic wk_valid;
  logic [TAGLEN-1:0] wk_tag;
  logic [DATALEN-1:0] wk_data;
  logic [NENT*ENTLEN-1:0] entry_vec;
  logic [NENT*VALLEN-1:0] value_vec;
  logic any_ready;
  logic [ENTLEN-1:0] oldest_entry;
  logic stall;
  logic issue_valid;
  logic [OPLEN-1:0] issue_op;
  logic [VALLEN-1:0] issue_age;
  logic [DATALEN-1:0] issue_src1, issue_src2;

  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  age;
    logic [31:0] s1;
    logic [31:0] s2;
  } rec_t;

  rec_t sb[$];
  int errors = 0;
  int checks = 0;
  logic [VALLEN-1:0] best_age;

  rs_entry_buffer #(
    .NENT(NENT), .ENTLEN(ENTLEN), .VALLEN(VALLEN),
    .TAGLEN(TAGLEN), .DATALEN(DATALEN), .OPLEN(OPLEN)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready),
    .alloc_op_i(alloc_op), .alloc_age_i(alloc_age),
    .alloc_src1_tag_i(alloc_t1), .alloc_src2_tag_i(alloc_t2),
    .alloc_src1_rdy_i(alloc_r1), .alloc_src2_rdy_i(alloc_r2),
    .alloc_src1_data_i(alloc_d1), .alloc_src2_data_i(alloc_d2),
    .wakeup_valid_i(wk_valid), .wakeup_tag_i(wk_tag), .wakeup_data_i(wk_data),
    .req_entry_vector_o(entry_vec), .req_value_vector_o(value_vec),
    .any_ready_o(any_ready), .oldest_entry_i(oldest_entry),
    .issue_stall_i(stall), .issue_valid_o(issue_valid),
    .issue_op_o(issue_op), .issue_age_o(issue_age),
    .issue_src1_o(issue_src1), .issue_src2_o(issue_src2)
  );

  always #5 clk = ~clk;

  // reference selection tree: smallest age wins, lowest index on ties
  always_comb begin
    best_age     = '1;
    oldest_entry = '0;
    for (int k = 0; k < NENT; k++) begin
      if (value_vec[k*VALLEN +: VALLEN] < best_age) begin
        best_age     = value_vec[k*VALLEN +: VALLEN];
        oldest_entry = ENTLEN'(k);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic alloc(input logic [7:0] op, input logic [7:0] age,
                       input logic [5:0] t1, input logic r1, input logic [31:0] d1,
                       input logic [5:0] t2, input logic r2, input logic [31:0] d2);
    alloc_valid = 1'b1;
    alloc_op = op; alloc_age = age;
    alloc_t1 = t1; alloc_r1 = r1; alloc_d1 = d1;
    alloc_t2 = t2; alloc_r2 = r2; alloc_d2 = d2;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] op, input logic [7:0] age,
                      input logic [31:0] s1, input logic [31:0] s2);
    rec_t r;
    r.op = op; r.age = age; r.s1 = s1; r.s2 = s2;
    sb.push_back(r);
  endtask

  task automatic chk_issue(input string tag);
    rec_t e;
    int n = 0;
    while (!issue_valid && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(issue_valid), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_op"},   32'(issue_op),  32'(e.op));
      chk({tag, "_age"},  32'(issue_age), 32'(e.age));
      chk({tag, "_src1"}, issue_src1,     e.s1);
      chk({tag, "_src2"}, issue_src2,     e.s2);
    end
  endtask

  initial begin
    rst_n = 1'b0; alloc_valid = 1'b0; alloc_op = '0; alloc_age = '0;
    alloc_t1 = '0; alloc_t2 = '0; alloc_r1 = 1'b0; alloc_r2 = 1'b0;
    alloc_d1 = '0; alloc_d2 = '0; wk_valid = 1'b0; wk_tag = '0; wk_data = '0;
    stall = 1'b0;
    repeat (2) tick();

    // reset state
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_issue_op", 32'(issue_op), 32'd0);
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst_any_ready", 32'(any_ready), 32'd0);
    chk("rst_value_vec", value_vec, 32'hFFFF_FFFF);
    chk("entry_vec", 32'(entry_vec), 32'h0000_00E4);

    // 1: single ready allocation, two-edge latency to the issue slot
    rst_n = 1'b1;
    push(8'h11, 8'd5, 32'hA, 32'hB);
    alloc(8'h11, 8'd5, 6'd1, 1'b1, 32'hA, 6'd2, 1'b1, 32'hB);
    chk("t1_any_ready", 32'(any_ready), 32'd1);
    chk("t1_value_vec", value_vec, 32'hFFFF_FF05);
    chk("t1_not_yet_issued", 32'(issue_valid), 32'd0);
    tick();
    chk_issue("t1");
    chk("t1_alloc_ready", 32'(alloc_ready), 32'd1);
    tick();
    chk("t1_idle", 32'(issue_valid), 32'd0);

    // 2: oldest-first ordering
    stall = 1'b1;
    alloc(8'h22, 8'd9, 6'd3, 1'b1, 32'h1, 6'd4, 1'b1, 32'h2);
    alloc(8'h33, 8'd3, 6'd5, 1'b1, 32'h3, 6'd6, 1'b1, 32'h4);
    push(8'h33, 8'd3, 32'h3, 32'h4);
    push(8'h22, 8'd9, 32'h1, 32'h2);
    chk("t2_value_vec", value_vec, 32'hFFFF_0309);
    stall = 1'b0;
    tick();
    chk_issue("t2a");
    tick();
    chk_issue("t2b");
    tick();
    chk("t2_drained", 32'(issue_valid), 32'd0);

    // 3: wakeup of a waiting source; a ready source with the same tag keeps its data
    alloc(8'h44, 8'd20, 6'd7, 1'b0, 32'h0, 6'd7, 1'b1, 32'h55);
    chk("t3_waiting", value_vec, 32'hFFFF_FFFF);
    wk_valid = 1'b1; wk_tag = 6'd8; wk_data = 32'hDEAD;
    tick();
    chk("t3_wrong_tag", value_vec, 32'hFFFF_FFFF);
    wk_tag = 6'd7; wk_data = 32'h1234;
    tick();
    wk_valid = 1'b0;
    chk("t3_woken", value_vec, 32'hFFFF_FF14);
    push(8'h44, 8'd20, 32'h1234, 32'h55);
    tick();
    chk_issue("t3");

    // 4: same-edge bypass into an allocating source
    wk_valid = 1'b1; wk_tag = 6'd4; wk_data = 32'hBEEF;
    alloc(8'h66, 8'd30, 6'd9, 1'b1, 32'h77, 6'd4, 1'b0, 32'h999);
    wk_valid = 1'b0;
    chk("t4_bypass_ready", value_vec, 32'hFFFF_FF1E);
    push(8'h66, 8'd30, 32'h77, 32'hBEEF);
    tick();
    chk_issue("t4");

    // 5: full buffer, dropped request, stall hold, then one issue per cycle
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alloc(8'(8'h80 + i), 8'(40 + i), 6'd10, 1'b1, 32'(i), 6'd11, 1'b1, 32'(32'h100 + i));
      push(8'(8'h80 + i), 8'(40 + i), 32'(i), 32'(32'h100 + i));
    end
    chk("t5_full", 32'(alloc_ready), 32'd0);
    alloc(8'h99, 8'd10, 6'd12, 1'b1, 32'h9, 6'd13, 1'b1, 32'h9);
    chk("t5_drop_full", 32'(alloc_ready), 32'd0);
    chk("t5_drop_vec", value_vec, 32'h2B2A_2928);
    repeat (3) tick();
    chk("t5_stall_valid", 32'(issue_valid), 32'd1);
    chk("t5_stall_op", 32'(issue_op), 32'h66);
    chk("t5_stall_age", 32'(issue_age), 32'd30);
    chk("t5_stall_vec", value_vec, 32'h2B2A_2928);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_issue($sformatf("t5_%0d", i));
    end
    tick();
    chk("t5_drained", 32'(issue_valid), 32'd0);
    chk("t5_alloc_ready", 32'(alloc_ready), 32'd1);

    // 6: asynchronous reset mid-stream
    push(8'h60, 8'd60, 32'h60, 32'h60);
    alloc(8'h60, 8'd60, 6'd1, 1'b1, 32'h60, 6'd1, 1'b1, 32'h60);
    alloc(8'h61, 8'd61, 6'd1, 1'b1, 32'h61, 6'd1, 1'b1, 32'h61);
    stall = 1'b1;
    chk_issue("t6");
    alloc(8'h62, 8'd62, 6'd1, 1'b1, 32'h62, 6'd1, 1'b1, 32'h62);
    alloc(8'h63, 8'd63, 6'd1, 1'b1, 32'h63, 6'd1, 1'b1, 32'h63);
    chk("t6_three_valid", value_vec, 32'hFF3F_3D3E);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(issue_valid), 32'd0);
    chk("t6_rst_op", 32'(issue_op), 32'd0);
    chk("t6_rst_age", 32'(issue_age), 32'd0);
    chk("t6_rst_src1", issue_src1, 32'd0);
    chk("t6_rst_src2", issue_src2, 32'd0);
    chk("t6_rst_vec", value_vec, 32'hFFFF_FFFF);
    chk("t6_rst_alloc_ready", 32'(alloc_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    stall = 1'b0;
    push(8'h70, 8'd70, 32'h7, 32'h8);
    alloc(8'h70, 8'd70, 6'd2, 1'b1, 32'h7, 6'd3, 1'b1, 32'h8);
    chk("t6_no_stale", 32'(issue_valid), 32'd0);
    tick();
    chk_issue("t6_post");
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rs_entry_buffer.md
Name: rs_entry_buffer

Overview:
- Reservation-station entry array upstream of the oldest-entry selection tree.
- Holds up to NENT waiting instructions and captures operands from a single result-broadcast bus.
- Presents per-entry ready ages to the selection tree, takes back the selected index, and moves that entry into a registered issue slot for the execute stage.

Parameters:
- NENT, 4: number of entries; power of two, at least 2.
- ENTLEN, 2: entry index width, equal to log2(NENT).
- VALLEN, 8: age (ROB tag) width. The value 2^VALLEN-1 is reserved as "not ready".
- TAGLEN, 6: physical source-tag width.
- DATALEN, 32: operand width.
- OPLEN, 8: opcode width.

Ports:
- clk_i, in, 1: clock.
- rst_n_i, in, 1: asynchronous active-low reset.
- alloc_valid_i, in, 1: allocation request.
- alloc_ready_o, out, 1: at least one free entry.
- alloc_op_i, in, OPLEN: opcode.
- alloc_age_i, in, VALLEN: age; smaller value means older.
- alloc_src1_tag_i / alloc_src2_tag_i, in, TAGLEN: source tags.
- alloc_src1_rdy_i / alloc_src2_rdy_i, in, 1: source already available.
- alloc_src1_data_i / alloc_src2_data_i, in, DATALEN: operand value when rdy=1.
- wakeup_valid_i, in, 1: result broadcast valid.
- wakeup_tag_i, in, TAGLEN: broadcast tag.
- wakeup_data_i, in, DATALEN: broadcast value.
- req_entry_vector_o, out, NENT*ENTLEN: slice k equals constant k.
- req_value_vector_o, out, NENT*VALLEN: slice k is the age of entry k if it is valid and both sources are ready, else all-ones.
- any_ready_o, out, 1: OR of per-entry ready.
- oldest_entry_i, in, ENTLEN: index returned by the selection tree.
- issue_stall_i, in, 1: execute stage cannot accept.
- issue_valid_o, out, 1: issue slot holds an instruction.
- issue_op_o, out, OPLEN: issued opcode.
- issue_age_o, out, VALLEN: issued age.
- issue_src1_o / issue_src2_o, out, DATALEN: issued operands.

Behaviour:
- Reset (async, rst_n_i=0): all entry valid bits clear; issue_valid_o=0; issue_op_o, issue_age_o, issue_src1_o and issue_src2_o are 0. Reset mid-operation discards all entries and the issue slot immediately. First allocation is possible at the first edge after release.
- Per-entry state: valid, op, age, and per source {tag, rdy, data}. ready = valid & src1.rdy & src2.rdy.
- Allocation:
  - alloc_ready_o = ~&valid, computed from registered state only. A slot freed by issue in the same cycle is not counted.
  - On an edge with alloc_valid_i & alloc_ready_o, the lowest-index free entry is written. alloc_valid_i is ignored when the buffer is full.
- Wakeup:
  - On an edge with wakeup_valid_i, every valid entry source with rdy=0 and tag==wakeup_tag_i sets rdy=1 and data=wakeup_data_i.
  - Same-edge bypass: an allocating source with rdy_i=0 and tag==wakeup_tag_i is written as rdy=1 with wakeup_data_i.
  - A source already ready is never overwritten.
- Request outputs are combinational from registered state. An entry written or woken at edge T is visible from T and issuable at edge T+1.
- Issue, on an edge with any_ready_o & ~issue_stall_i:
  - Entry oldest_entry_i is copied into the issue slot, issue_valid_o=1, and that entry's valid clears.
  - If oldest_entry_i selects a non-ready entry (protocol error), no issue occurs and issue_valid_o=0.
- Issue with no ready entry: on an edge with ~any_ready_o & ~issue_stall_i, issue_valid_o=0.
- Stall: while issue_stall_i=1 the issue slot holds all its values and no entry is freed.
- Allocation and issue in the same cycle always target different entries. Wakeup in the same cycle as issue of an unrelated entry applies normally.
- Latency: allocation with both sources ready at edge T gives issue_valid_o=1 after edge T+1, given no stall and that entry is the oldest.
- Ages equal to 2^VALLEN-1 at allocation are illegal (assertion in simulation).

Test Plan:
1. Reset, then allocate op=0x11, age=5, both rdy, data 0xA/0xB -> any_ready_o=1 next cycle, value slice0=5. After the following edge: issue_valid_o=1, issue_op_o=0x11, issue_src1_o=0xA, issue_src2_o=0xB, alloc_ready_o=1.
2. Allocate age 9 then age 3, both ready, with the tree driven by a reference min model -> issue order is age 3 then age 9; issue_valid_o then drops to 0.
3. Allocate src1 tag=7 not ready -> value slice stays 0xFF. Wakeup tag=7 data=0x1234 -> next cycle slice shows age, and issue_src1_o=0x1234. A wakeup with tag 8 has no effect.
4. Wakeup tag=4 in the same edge as allocating src2 tag=4 not ready -> entry is ready the next cycle with src2=wakeup data.
5. Fill 4 entries -> alloc_ready_o=0 and a 5th request is dropped. Hold issue_stall_i=1 for 3 cycles -> issue slot unchanged and no entry freed. Release -> one issue per cycle.
6. Assert rst_n_i mid-stream with 3 valid entries and issue_valid_o=1 -> outputs zero immediately, alloc_ready_o=1 after release, and no stale issue.
